pfixed_to_pfloat: RTL and testbench

Multi-cycle converter from signed two's-complement fixed point to IEEE-754 single-precision float. It is the inverse path of the float-to-fixed converter. It uses the same Begin/ACK FSM handshake, so a controller can chain the two. Normalisation is sequential: one left shift per cycle, with round-to-nearest-even before packing.

---
 rtl/pfixed_to_pfloat.sv | 99 +++++++++
 tb/tb_pfixed_to_pfloat.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pfixed_to_pfloat.sv
// Sequential converter from signed Q(31-FRAC_BITS).FRAC_BITS fixed point to
// IEEE-754 single precision: one normalising shift per cycle, then round-to-nearest-even.
module pfixed_to_pfloat #(
  parameter int FRAC_BITS = 26
) (
  input  logic        CLK,
  input  logic        RST_FF,
  input  logic        Begin_FSM_FF,
  input  logic [31:0] P,
  output logic        ACK_FF,
  output logic [31:0] F,
  output logic        BUSY,
  output logic [2:0]  dbg_state
);

  // Handshake: Begin_FSM_FF is sampled only while IDLE and otherwise ignored
  // (no queueing); ACK_FF is a registered one-cycle pulse and F holds its value
  // until the next conversion overwrites it.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    PACK  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [8:0] EXP_INIT = 9'(127 + 31 - FRAC_BITS);

  state_t      state, state_nx;
  logic        sign;
  logic [31:0] mag;
  logic [8:0]  exp_r;
  logic [22:0] mant;

  logic [31:0] mag_load;
  logic        guard, sticky, round_up;
  logic [23:0] mant_sum;

  assign mag_load = P[31] ? (~P + 32'd1) : P;
  assign guard    = mag[7];
  assign sticky   = |mag[6:0];
  assign round_up = guard & (sticky | mag[8]);
  assign mant_sum = {1'b0, mag[30:8]} + {23'd0, round_up};

  assign BUSY      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Begin_FSM_FF) state_nx = LOAD;
      LOAD:    state_nx = (mag_load == 32'd0) ? DONE : NORM;
      NORM:    if (mag[31]) state_nx = ROUND;
      ROUND:   state_nx = PACK;
      PACK:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST_FF) begin
      state  <= IDLE;
      sign   <= 1'b0;
      mag    <= 32'd0;
      exp_r  <= 9'd0;
      mant   <= 23'd0;
      F      <= 32'd0;
      ACK_FF <= 1'b0;
    end else begin
      state  <= state_nx;
      ACK_FF <= (state == DONE);
      case (state)
        LOAD: begin
          sign  <= P[31];
          mag   <= mag_load;
          exp_r <= EXP_INIT;
          // Zero has no leading one to find; it bypasses normalisation as +0.
          if (mag_load == 32'd0) F <= 32'd0;
        end
        NORM: begin
          if (!mag[31]) begin
            mag   <= mag << 1;
            exp_r <= exp_r - 9'd1;
          end
        end
        ROUND: begin
          // A carry out of the mantissa leaves it at zero and bumps the exponent.
          mant <= mant_sum[22:0];
          if (mant_sum[23]) exp_r <= exp_r + 9'd1;
        end
        PACK: F <= {sign, exp_r[7:0], mant};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pfixed_to_pfloat.sv
// Directed bench for pfixed_to_pfloat (FRAC_BITS=26): results, latencies,
// rounding, handshake and reset behaviour against hand-computed values.
module tb_pfixed_to_pfloat;

  logic        clk;
  logic        rst;
  logic        begin_s;
  logic [31:0] p;
  logic        ack;
  logic [31:0] f;
  logic        busy;
  logic [2:0]  dbg_state;

  int n_cmp;
  int n_bad;

  pfixed_to_pfloat #(.FRAC_BITS(26)) dut (
    .CLK          (clk),
    .RST_FF       (rst),
    .Begin_FSM_FF (begin_s),
    .P            (p),
    .ACK_FF       (ack),
    .F            (f),
    .BUSY         (busy),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: one-cycle Begin pulse, then wait (bounded) for ACK.
  // lat counts rising edges after the edge that sampled Begin; -1 on timeout.
  task automatic run_conv(input logic [31:0] pv, output int lat, output logic [31:0] fv);
    lat = -1;
    fv  = 32'hxxxxxxxx;
    @(negedge clk);
    p       = pv;
    begin_s = 1'b1;
    @(posedge clk);
    #1 begin_s = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        lat = i;
        fv  = f;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; begin_s = 1'b0; p = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack got %b want 0", ack); end
    n_cmp++; if (f !== 32'd0) begin n_bad++; $display("FAIL reset_f got %h want 00000000", f); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (dbg_state !== 3'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] fv;
    run_conv(32'h04000000, lat, fv);
    n_cmp++; if (fv !== 32'h3F800000) begin n_bad++; $display("FAIL one_f got %h want 3f800000", fv); end
    n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL one_lat got %0d want 10", lat); end
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL one_ack_pulse got %b want 0", ack); end
    n_cmp++; if (f !== 32'h3F800000) begin n_bad++; $display("FAIL one_f_hold got %h want 3f800000", f); end
    run_conv(32'hC3000000, lat, fv);
    n_cmp++; if (fv !== 32'hC1740000) begin n_bad++; $display("FAIL neg15_f got %h want c1740000", fv); end
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL neg15_lat got %0d want 7", lat); end
    run_conv(32'h3D000000, lat, fv);
    n_cmp++; if (fv !== 32'h41740000) begin n_bad++; $display("FAIL pos15_f got %h want 41740000", fv); end
  endtask

  task automatic test_boundaries();
    int lat; logic [31:0] fv;
    run_conv(32'h00000000, lat, fv);
    n_cmp++; if (fv !== 32'h00000000) begin n_bad++; $display("FAIL zero_f got %h want 00000000", fv); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL zero_lat got %0d want 2", lat); end
    run_conv(32'h80000000, lat, fv);
    n_cmp++; if (fv !== 32'hC2000000) begin n_bad++; $display("FAIL minneg_f got %h want c2000000", fv); end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL minneg_lat got %0d want 5", lat); end
    run_conv(32'h00000001, lat, fv);
    n_cmp++; if (fv !== 32'h32800000) begin n_bad++; $display("FAIL lsb_f got %h want 32800000", fv); end
    n_cmp++; if (lat !== 36) begin n_bad++; $display("FAIL lsb_lat got %0d want 36", lat); end
  endtask

  // Guard bit for a value in [1,2) at FRAC_BITS=26 sits at P[2]; mantissa LSB at P[3].
  task automatic test_rounding();
    int lat; logic [31:0] fv;
    run_conv(32'h7FFFFFFF, lat, fv);
    n_cmp++; if (fv !== 32'h42000000) begin n_bad++; $display("FAIL carry_f got %h want 42000000", fv); end
    n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL carry_lat got %0d want 6", lat); end
    run_conv(32'h04000004, lat, fv);
    n_cmp++; if (fv !== 32'h3F800000) begin n_bad++; $display("FAIL tie_even_f got %h want 3f800000", fv); end
    run_conv(32'h0400000C, lat, fv);
    n_cmp++; if (fv !== 32'h3F800002) begin n_bad++; $display("FAIL tie_odd_f got %h want 3f800002", fv); end
    run_conv(32'h04000005, lat, fv);
    n_cmp++; if (fv !== 32'h3F800001) begin n_bad++; $display("FAIL above_tie_f got %h want 3f800001", fv); end
    run_conv(32'h04000080, lat, fv);
    n_cmp++; if (fv !== 32'h3F800010) begin n_bad++; $display("FAIL exact_f got %h want 3f800010", fv); end
  endtask

  task automatic test_ignore_begin();
    int acks; int first_lat; logic [31:0] fv;
    acks = 0; first_lat = -1; fv = 32'd0;
    @(negedge clk);
    p = 32'h04000000; begin_s = 1'b1;
    @(posedge clk);
    #1 begin_s = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      if (i == 3) begin p = 32'h3D000000; begin_s = 1'b1; end
      if (i == 4) begin_s = 1'b0;
      @(posedge clk);
      #1;
      if (ack) begin
        acks++;
        if (first_lat < 0) begin first_lat = i; fv = f; end
      end
    end
    n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL ignore_ack_count got %0d want 1", acks); end
    n_cmp++; if (first_lat !== 10) begin n_bad++; $display("FAIL ignore_lat got %0d want 10", first_lat); end
    n_cmp++; if (fv !== 32'h3F800000) begin n_bad++; $display("FAIL ignore_f got %h want 3f800000", fv); end
  endtask

  task automatic test_back_to_back();
    int acks; int idle_cnt; int ack_at[2]; logic [31:0] fa[2];
    acks = 0; idle_cnt = 0; ack_at[0] = -1; ack_at[1] = -1; fa[0] = 32'd0; fa[1] = 32'd0;
    @(negedge clk);
    p = 32'h3D000000; begin_s = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        if (acks < 2) begin ack_at[acks] = i; fa[acks] = f; end
        acks++;
      end
      if (acks == 1 && !busy) idle_cnt++;
    end
    begin_s = 1'b0;
    n_cmp++; if (acks !== 2) begin n_bad++; $display("FAIL b2b_ack_count got %0d want 2", acks); end
    n_cmp++; if (ack_at[0] !== 7) begin n_bad++; $display("FAIL b2b_ack0_at got %0d want 7", ack_at[0]); end
    n_cmp++; if (ack_at[1] !== 15) begin n_bad++; $display("FAIL b2b_ack1_at got %0d want 15", ack_at[1]); end
    n_cmp++; if (idle_cnt !== 1) begin n_bad++; $display("FAIL b2b_idle_cycles got %0d want 1", idle_cnt); end
    n_cmp++; if (fa[0] !== 32'h41740000) begin n_bad++; $display("FAIL b2b_f0 got %h want 41740000", fa[0]); end
    n_cmp++; if (fa[1] !== 32'h41740000) begin n_bad++; $display("FAIL b2b_f1 got %h want 41740000", fa[1]); end
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_stop_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int acks; int lat; logic [31:0] fv;
    acks = 0;
    @(negedge clk);
    p = 32'h00000001; begin_s = 1'b1;
    @(posedge clk);
    #1 begin_s = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (dbg_state !== 3'd2) begin n_bad++; $display("FAIL rmid_in_norm got %0d want 2", dbg_state); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
    n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rmid_ack got %b want 0", ack); end
    n_cmp++; if (f !== 32'd0) begin n_bad++; $display("FAIL rmid_f got %h want 00000000", f); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL rmid_no_ack got %0d want 0", acks); end
    run_conv(32'hC3000000, lat, fv);
    n_cmp++; if (fv !== 32'hC1740000) begin n_bad++; $display("FAIL rmid_fresh_f got %h want c1740000", fv); end
    n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL rmid_fresh_lat got %0d want 7", lat); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; begin_s = 1'b0; p = 32'd0;
    test_reset();
    test_basic();
    test_boundaries();
    test_rounding();
    test_ignore_begin();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
